vec_stim_player: RTL and testbench
==================================

// Module: vec_stim_player
// PURPOSE
//  Synthesizable, parametrised stimulus player / response capturer for ISCAS-class combinational DUTs in aging runs.
//  Holds a vector RAM loaded over a write port and replays vectors on dut_in with a programmable settle time.
//  Captures dut_out per vector and compacts responses into a MISR signature.
//  Supports single-pass, N-repeat and continuous (stress) replay with clean stop.
// PARAMETERS
//  IN_W    82                  stimulus vector width (DUT input count)
//  OUT_W   64                  response width (DUT output count)
//  DEPTH   16                  vector RAM entries
//  ADDR_W  4                   RAM address width, clog2(DEPTH)
//  SETTLE  1                   cycles each vector is held before capture (>=1)
//  POLY    64'h1B              MISR feedback polynomial, low OUT_W bits used
// PORTS
//  clk       in   1         single clock, posedge
//  rst_n     in   1         asynchronous active-low reset
//  ld_we     in   1         vector RAM write enable
//  ld_addr   in   ADDR_W    RAM write address
//  ld_data   in   IN_W      RAM write data
//  start     in   1         begin run (sampled in IDLE only)
//  stop      in   1         abort continuous/repeat run at next vector boundary
//  mode      in   2         00 single pass, 01 repeat rep_cnt passes, 1x continuous
//  rep_cnt   in   16        pass count for mode 01 (0 treated as 1)
//  num_vec   in   ADDR_W+1  vectors per pass; 0 = start ignored, >DEPTH clamped to DEPTH
//  dut_in    out  IN_W      registered stimulus to DUT
//  dut_out   in   OUT_W     DUT response
//  cap_valid out  1         1-cycle pulse: cap_data/cap_idx valid
//  cap_data  out  OUT_W     captured response
//  cap_idx   out  ADDR_W    RAM index of the vector that produced cap_data
//  signature out  OUT_W     MISR state
//  pass_cnt  out  16        completed passes this run (wraps at 2^16)
//  busy      out  1         run in progress
//  done      out  1         level; set at run end, cleared by next accepted start
// BEHAVIOUR
//  - Reset: all outputs and state 0, FSM IDLE; vector RAM not reset (contents survive rst_n).
//  - FSM: IDLE -> RUN -> DONE -> IDLE. DONE lasts 1 cycle, then IDLE with done=1 held.
//  - Accepted start at edge E0 (IDLE, num_vec!=0): signature, pass_cnt, idx cleared; done=0; busy=1;
//    dut_in<=mem[0] at edge E0+1.
//  - Vector held SETTLE cycles: dut_out sampled at edge Ek+SETTLE; at that same edge the next vector is loaded.
//  - Capture edge: cap_data<=dut_out, cap_idx<=idx, cap_valid<=1 (next cycle), signature updated.
//  - MISR: sig <= (sig<<1) ^ (sig[OUT_W-1] ? POLY : 0) ^ dut_out.
//  - idx wraps num_vec-1 -> 0; pass_cnt++ on capture of last index.
//  - End conditions:
//    - mode 00: after 1 pass;
//    - mode 01: after rep_cnt passes;
//    - mode 1x: only on stop.
//  - stop seen while RUN: current vector still captured, no new vector loaded, then DONE.
//    stop in IDLE ignored.
//  - Run end: busy=0 and done=1 on the cycle after the final cap_valid; dut_in holds last vector.
//  - start while busy ignored; ld_we while busy ignored; ld_addr>=DEPTH ignored.
//  - rst_n mid-run: outputs 0 immediately (async), run lost; restart replays identically.
//  - mode/num_vec/rep_cnt latched at accepted start; later changes have no effect on the run.
// TESTING
//  1. Load mem[0..3]=1,2,3,4; loop dut_out=dut_in[63:0]; SETTLE=1, mode 00, num_vec 4, start
//     -> dut_in 1,2,3,4 on consecutive cycles; cap_data 1..4, cap_idx 0..3;
//     signature=64'h2, pass_cnt=1, done=1, busy=0.
//  2. SETTLE=3, same load -> each vector held 3 cycles, cap_valid every 3rd cycle, signature=64'h2.
//  3. mode 01, rep_cnt=3, num_vec=2 -> 6 captures with cap_idx 0,1,0,1,0,1; pass_cnt=3; done.
//  4. mode 10, stop pulsed after 5th cap_valid -> exactly one more cap_valid, then busy=0, done=1.
//  5. rst_n low mid-run of test 1 -> all outputs 0 at once; rerun without reload -> signature=64'h2.
//  6. start with num_vec=0 -> busy stays 0; ld_we to mem[0] during run -> replay of mem[0] unchanged.

Source files
------------

// File: rtl/vec_stim_if.sv
// vec_stim_if: bus between the stimulus player and whoever drives it.
//   Load port   : ld_we / ld_addr / ld_data       (vector RAM writes)
//   Run control : start / stop / mode / rep_cnt / num_vec
//   DUT side    : dut_in (stimulus out), dut_out (response in)
//   Results     : cap_valid / cap_data / cap_idx, signature, pass_cnt, busy, done
// master = controller/testbench side, slave = vec_stim_player.
interface vec_stim_if #(
  parameter int IN_W   = 82,
  parameter int OUT_W  = 64,
  parameter int ADDR_W = 4
);
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [IN_W-1:0]   ld_data;
  logic              start;
  logic              stop;
  logic [1:0]        mode;
  logic [15:0]       rep_cnt;
  logic [ADDR_W:0]   num_vec;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              cap_valid;
  logic [OUT_W-1:0]  cap_data;
  logic [ADDR_W-1:0] cap_idx;
  logic [OUT_W-1:0]  signature;
  logic [15:0]       pass_cnt;
  logic              busy;
  logic              done;

  modport master (
    output ld_we, ld_addr, ld_data, start, stop, mode, rep_cnt, num_vec, dut_out,
    input  dut_in, cap_valid, cap_data, cap_idx, signature, pass_cnt, busy, done
  );

  modport slave (
    input  ld_we, ld_addr, ld_data, start, stop, mode, rep_cnt, num_vec, dut_out,
    output dut_in, cap_valid, cap_data, cap_idx, signature, pass_cnt, busy, done
  );
endinterface

// File: rtl/vec_stim_player.sv
// vec_stim_player: replays vectors from a small RAM onto a combinational DUT,
// holds each for SETTLE cycles, captures the response and folds it into a MISR.
// Ports:
//   clk, rst_n : clock (posedge), asynchronous active-low reset
//   bus        : vec_stim_if.slave (load port, run control, DUT in/out, results)
// Run modes: 00 single pass, 01 rep_cnt passes (0 -> 1), 1x continuous until stop.
// The vector RAM is not reset so a run can be replayed after rst_n without reload.
module vec_stim_player #(
  parameter int          IN_W   = 82,
  parameter int          OUT_W  = 64,
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = 4,
  parameter int          SETTLE = 1,
  parameter logic [63:0] POLY   = 64'h1B
) (
  input logic      clk,
  input logic      rst_n,
  vec_stim_if.slave bus
);

  localparam logic [OUT_W-1:0] POLY_W = POLY[OUT_W-1:0];
  localparam int               CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [ADDR_W:0]  DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic              primed;    // first vector of the run has been driven
  logic              stop_req;  // stop seen during the run, honoured at next capture
  logic [CNT_W-1:0]  cnt;       // cycles the current vector has been held
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W:0]   nv_q;
  logic [1:0]        mode_q;
  logic [15:0]       reps_q;

  logic [IN_W-1:0]   mem [DEPTH];

  logic [ADDR_W:0]   nv_clamp;
  logic              last_idx;
  logic [15:0]       pass_nxt;
  logic              run_end;
  logic              cap_now;
  logic [ADDR_W-1:0] idx_nxt;
  logic [OUT_W-1:0]  misr_nxt;

  assign nv_clamp = (bus.num_vec > DEPTH_W) ? DEPTH_W : bus.num_vec;
  assign last_idx = ({1'b0, idx} == (nv_q - 1'b1));
  assign pass_nxt = bus.pass_cnt + 16'd1;
  assign idx_nxt  = last_idx ? '0 : idx + 1'b1;
  assign cap_now  = (state == S_RUN) && primed && (cnt == CNT_W'(SETTLE - 1));
  assign misr_nxt = {bus.signature[OUT_W-2:0], 1'b0}
                  ^ (bus.signature[OUT_W-1] ? POLY_W : '0)
                  ^ bus.dut_out;
  // A stop arriving on the capture edge itself also ends the run there.
  assign run_end  = stop_req | bus.stop
                  | (last_idx & ((mode_q == 2'b00) | ((mode_q == 2'b01) & (pass_nxt == reps_q))));

  // Vector RAM: writes locked out while a run is in progress.
  always_ff @(posedge clk) begin
    if (bus.ld_we && !bus.busy && ({1'b0, bus.ld_addr} < DEPTH_W))
      mem[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      primed        <= 1'b0;
      stop_req      <= 1'b0;
      cnt           <= '0;
      idx           <= '0;
      nv_q          <= '0;
      mode_q        <= '0;
      reps_q        <= '0;
      bus.dut_in    <= '0;
      bus.cap_valid <= 1'b0;
      bus.cap_data  <= '0;
      bus.cap_idx   <= '0;
      bus.signature <= '0;
      bus.pass_cnt  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.cap_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start && (bus.num_vec != '0)) begin
            bus.signature <= '0;
            bus.pass_cnt  <= '0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b1;
            idx           <= '0;
            cnt           <= '0;
            primed        <= 1'b0;
            stop_req      <= 1'b0;
            nv_q          <= nv_clamp;
            mode_q        <= bus.mode;
            reps_q        <= (bus.rep_cnt == 16'd0) ? 16'd1 : bus.rep_cnt;
            state         <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.stop) stop_req <= 1'b1;
          if (!primed) begin
            bus.dut_in <= mem[idx];
            primed     <= 1'b1;
            cnt        <= '0;
          end else if (cap_now) begin
            bus.cap_data  <= bus.dut_out;
            bus.cap_idx   <= idx;
            bus.cap_valid <= 1'b1;
            bus.signature <= misr_nxt;
            if (last_idx) bus.pass_cnt <= pass_nxt;
            if (run_end) begin
              // dut_in keeps the last vector; nothing new is launched.
              state <= S_DONE;
            end else begin
              idx        <= idx_nxt;
              bus.dut_in <= mem[idx_nxt];
              cnt        <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_stim_player.sv
// Bench for vec_stim_player: two instances (SETTLE=1 and SETTLE=3) with the
// DUT side looped back through a fixed response function. Each run is
// predicted from the mode rules (expected capture list, pass count, MISR)
// and compared cycle by cycle.
module tb_vec_stim_player;
  localparam int          IN_W   = 82;
  localparam int          OUT_W  = 64;
  localparam int          DEPTH  = 16;
  localparam int          ADDR_W = 4;
  localparam int          NU     = 2;
  localparam logic [63:0] POLY   = 64'h1B;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n_r   [NU];
  logic              ld_we_r   [NU];
  logic [ADDR_W-1:0] ld_addr_r [NU];
  logic [IN_W-1:0]   ld_data_r [NU];
  logic              start_r   [NU];
  logic              stop_r    [NU];
  logic [1:0]        mode_r    [NU];
  logic [15:0]       rep_r     [NU];
  logic [ADDR_W:0]   nv_r      [NU];

  logic              cv  [NU];
  logic              dn  [NU];
  logic              bz  [NU];
  logic [IN_W-1:0]   din [NU];
  logic [OUT_W-1:0]  cd  [NU];
  logic [OUT_W-1:0]  sg  [NU];
  logic [ADDR_W-1:0] ci  [NU];
  logic [15:0]       pc  [NU];

  vec_stim_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bi [NU] ();

  for (genvar g = 0; g < NU; g++) begin : g_u
    assign bi[g].ld_we   = ld_we_r[g];
    assign bi[g].ld_addr = ld_addr_r[g];
    assign bi[g].ld_data = ld_data_r[g];
    assign bi[g].start   = start_r[g];
    assign bi[g].stop    = stop_r[g];
    assign bi[g].mode    = mode_r[g];
    assign bi[g].rep_cnt = rep_r[g];
    assign bi[g].num_vec = nv_r[g];
    assign bi[g].dut_out = bi[g].dut_in[63:0] ^ {{(OUT_W-(IN_W-64)){1'b0}}, bi[g].dut_in[IN_W-1:64]};
    assign cv[g]  = bi[g].cap_valid;
    assign dn[g]  = bi[g].done;
    assign bz[g]  = bi[g].busy;
    assign din[g] = bi[g].dut_in;
    assign cd[g]  = bi[g].cap_data;
    assign sg[g]  = bi[g].signature;
    assign ci[g]  = bi[g].cap_idx;
    assign pc[g]  = bi[g].pass_cnt;

    vec_stim_player #(
      .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .SETTLE((g == 0) ? 1 : 3), .POLY(POLY)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n_r[g]),
      .bus   (bi[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [IN_W-1:0] mem_m [NU][DEPTH];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] resp(input logic [IN_W-1:0] v);
    return v[63:0] ^ {{(OUT_W-(IN_W-64)){1'b0}}, v[IN_W-1:64]};
  endfunction

  task automatic load(input int u, input int a, input logic [IN_W-1:0] d);
    ld_we_r[u]   = 1'b1;
    ld_addr_r[u] = ADDR_W'(a);
    ld_data_r[u] = d;
    @(negedge clk);
    ld_we_r[u]   = 1'b0;
    mem_m[u][a]  = d;
  endtask

  task automatic chk_zero(input int u, input string t);
    chk($sformatf("u%0d %s busy", u, t), bz[u], 0);
    chk($sformatf("u%0d %s done", u, t), dn[u], 0);
    chk($sformatf("u%0d %s cap_valid", u, t), cv[u], 0);
    chk($sformatf("u%0d %s dut_in", u, t), din[u], 0);
    chk($sformatf("u%0d %s sig", u, t), sg[u], 0);
    chk($sformatf("u%0d %s pass_cnt", u, t), pc[u], 0);
    chk($sformatf("u%0d %s cap_data", u, t), cd[u], 0);
  endtask

  // One run. stop_k>0: pulse stop on the cycle after the stop_k-th cap_valid.
  // poke: mid-run RAM write to mem[0] and a second start, both to be ignored.
  task automatic run(input int u, input logic [1:0] md, input logic [15:0] rep,
                     input logic [ADDR_W:0] nv, input int stop_k, input bit poke,
                     output logic [OUT_W-1:0] sig_o);
    int n, total, ncap, cyc, lastc, st;
    logic [OUT_W-1:0] es;
    st = (u == 0) ? 1 : 3;
    n  = (int'(nv) > DEPTH) ? DEPTH : int'(nv);
    if (md[1])           total = stop_k + 1;
    else if (md == 2'b01) total = n * ((rep == 16'd0) ? 1 : int'(rep));
    else                 total = n;
    if (stop_k > 0 && stop_k + 1 < total) total = stop_k + 1;
    es = '0;
    for (int i = 0; i < total; i++)
      es = (es << 1) ^ (es[OUT_W-1] ? POLY[OUT_W-1:0] : '0) ^ resp(mem_m[u][i % n]);

    mode_r[u] = md; rep_r[u] = rep; nv_r[u] = nv; start_r[u] = 1'b1;
    @(negedge clk);
    start_r[u] = 1'b0;
    cyc = 1; ncap = 0; lastc = 0;
    chk($sformatf("u%0d busy_on", u), bz[u], 1);
    chk($sformatf("u%0d done_clr", u), dn[u], 0);
    while (1) begin
      if (cyc == 1) begin
        mode_r[u] = 2'($urandom); rep_r[u] = 16'($urandom); nv_r[u] = (ADDR_W+1)'($urandom);
      end
      ld_we_r[u] = poke && (cyc == 2);
      start_r[u] = poke && (cyc == 2);
      if (poke && cyc == 2) begin
        ld_addr_r[u] = '0;
        ld_data_r[u] = IN_W'({$urandom, $urandom, $urandom});
      end
      if (cv[u]) begin
        if (ncap < total) begin
          chk($sformatf("u%0d cap_idx[%0d]", u, ncap), ci[u], ncap % n);
          chk($sformatf("u%0d cap_data[%0d]", u, ncap), cd[u], resp(mem_m[u][ncap % n]));
        end else begin
          chk($sformatf("u%0d extra_cap", u), ncap + 1, total);
        end
        if (ncap == 0) chk($sformatf("u%0d first_lat", u), cyc, st + 2);
        else           chk($sformatf("u%0d cap_gap", u), cyc - lastc, st);
        lastc = cyc;
        ncap++;
      end
      stop_r[u] = cv[u] && (stop_k > 0) && (ncap == stop_k);
      if (dn[u] || cyc > 4000) break;
      @(negedge clk);
      cyc++;
    end
    stop_r[u] = 1'b0; ld_we_r[u] = 1'b0; start_r[u] = 1'b0;
    chk($sformatf("u%0d run_timeout", u), dn[u], 1);
    chk($sformatf("u%0d done_lat", u), cyc, lastc + 1);
    chk($sformatf("u%0d busy_off", u), bz[u], 0);
    chk($sformatf("u%0d ncap", u), ncap, total);
    chk($sformatf("u%0d sig", u), sg[u], es);
    chk($sformatf("u%0d pass_cnt", u), pc[u], 16'(total / n));
    chk($sformatf("u%0d dut_in_hold", u), din[u], mem_m[u][(total - 1) % n]);
    sig_o = sg[u];
  endtask

  task automatic suite(input int u);
    logic [OUT_W-1:0] s;
    logic [1:0]       md;
    int               sk;
    for (int a = 0; a < 4; a++) load(u, a, IN_W'(a + 1));
    run(u, 2'b00, 16'd0, 5'd4, 0, 1'b0, s);
    chk($sformatf("u%0d t1_sig_const", u), s, 64'h2);
    run(u, 2'b01, 16'd3, 5'd2, 0, 1'b0, s);
    run(u, 2'b10, 16'd0, 5'd4, 5, 1'b0, s);
    // stop while idle and a start with num_vec=0 must both be ignored
    stop_r[u] = 1'b1; @(negedge clk); stop_r[u] = 1'b0;
    nv_r[u] = '0; start_r[u] = 1'b1; @(negedge clk); start_r[u] = 1'b0;
    @(negedge clk);
    chk($sformatf("u%0d nv0_busy", u), bz[u], 0);
    chk($sformatf("u%0d nv0_done", u), dn[u], 1);
    // reset in the middle of a run
    mode_r[u] = 2'b00; nv_r[u] = 5'd4; start_r[u] = 1'b1;
    @(negedge clk); start_r[u] = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n_r[u] = 1'b0;
    #1;
    chk_zero(u, "midrst");
    @(negedge clk); rst_n_r[u] = 1'b1; @(negedge clk);
    run(u, 2'b00, 16'd0, 5'd4, 0, 1'b0, s);
    chk($sformatf("u%0d t5_sig_const", u), s, 64'h2);
    run(u, 2'b01, 16'd2, 5'd4, 0, 1'b1, s);
    // random contents and run shapes
    for (int a = 0; a < DEPTH; a++) load(u, a, IN_W'({$urandom, $urandom, $urandom}));
    for (int it = 0; it < 8; it++) begin
      md = 2'($urandom_range(0, 3));
      if (md[1])                                      sk = int'($urandom_range(1, 40));
      else if (md == 2'b01 && $urandom_range(0, 2) == 0) sk = int'($urandom_range(1, 20));
      else                                            sk = 0;
      run(u, md, 16'($urandom_range(0, 3)), (ADDR_W+1)'($urandom_range(1, 31)), sk, 1'b0, s);
    end
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      rst_n_r[u] = 1'b1; ld_we_r[u] = 1'b0; ld_addr_r[u] = '0; ld_data_r[u] = '0;
      start_r[u] = 1'b0; stop_r[u] = 1'b0; mode_r[u] = '0; rep_r[u] = '0; nv_r[u] = '0;
    end
    #1;
    for (int u = 0; u < NU; u++) rst_n_r[u] = 1'b0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < NU; u++) chk_zero(u, "reset");
    for (int u = 0; u < NU; u++) rst_n_r[u] = 1'b1;
    @(negedge clk);
    for (int u = 0; u < NU; u++) suite(u);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test want end before time limit");
    $fatal(1, "watchdog");
  end

endmodule
